// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, control-vector bit positions, step/mode/class types and decode helpers
package cpu_pkg;

   localparam int CTRL_W = 29;

   localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam int B_PC_OUT = 0, B_ZHIGH_OUT = 1, B_ZLOW_OUT = 2, B_MDR_OUT = 3;
   localparam int B_BA_OUT = 4, B_R_IN = 5, B_R_OUT = 6, B_HI_OUT = 7, B_LO_OUT = 8;
   localparam int B_INPORT_OUT = 9, B_C_OUT = 10, B_MAR_IN = 11, B_PC_IN = 12;
   localparam int B_MDR_IN = 13, B_IR_IN = 14, B_Y_IN = 15, B_INC_PC = 16, B_READ = 17;
   localparam int B_WRITE = 18, B_GRA = 19, B_GRB = 20, B_GRC = 21, B_HI_IN = 22;
   localparam int B_LO_IN = 23, B_ZHIGH_IN = 24, B_ZLOW_IN = 25, B_CON_IN = 26;
   localparam int B_OUTPORT_IN = 27;

   typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, T8, T9} step_t;

   typedef enum logic [1:0] {M_IDLE, M_RUN, M_HALT} mode_t;

   typedef enum logic [3:0] {
      C_RTYPE, C_IMM, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST, C_BR,
      C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
   } class_t;

   // One-hot strobe at a given control-vector position
   function automatic logic [CTRL_W-1:0] sb(input int idx);
      sb = '0;
      sb[idx] = 1'b1;
   endfunction

   // Group opcodes by their execute sequence; unused opcodes behave as nop
   function automatic class_t op_class(input logic [4:0] op);
      if (op inside {[OP_ADD:OP_SHL]}) return C_RTYPE;
      if (op inside {OP_ADDI, OP_ANDI, OP_ORI}) return C_IMM;
      if (op inside {OP_NEG, OP_NOT}) return C_UNARY;
      if (op inside {OP_MUL, OP_DIV}) return C_MULDIV;
      if (op == OP_LD) return C_LD;
      if (op == OP_LDI) return C_LDI;
      if (op == OP_ST) return C_ST;
      if (op == OP_BR) return C_BR;
      if (op == OP_JR) return C_JR;
      if (op == OP_JAL) return C_JAL;
      if (op == OP_IN) return C_IN;
      if (op == OP_OUT) return C_OUT;
      if (op == OP_MFHI) return C_MFHI;
      if (op == OP_MFLO) return C_MFLO;
      if (op == OP_HALT) return C_HALT;
      return C_NOP;
   endfunction

   // Final execute step of each instruction class
   function automatic step_t last_step(input class_t c);
      case (c)
         C_LD: return T9;
         C_ST: return T8;
         C_MULDIV, C_BR: return T7;
         C_RTYPE, C_IMM, C_LDI: return T6;
         C_UNARY, C_JAL: return T5;
         default: return T4;
      endcase
   endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode: maps (step, opcode, con_ff) to datapath strobes and ALU code
module control_decode
   import cpu_pkg::*;
(
   input  step_t             step,
   input  logic [4:0]        opcode,
   input  logic              con_ff,
   output logic [CTRL_W-1:0] ctrl,
   output logic [4:0]        alu_op
);

   class_t     cls;
   logic [4:0] alu_sel;

   assign cls = op_class(opcode);

   // Strobes for the current step: fetch first, then per-class execute
   always_comb begin
      ctrl = '0;
      case (step)
         T0: ctrl = sb(B_PC_OUT) | sb(B_MAR_IN) | sb(B_INC_PC) | sb(B_PC_IN);
         T1: ctrl = sb(B_READ);
         T2: ctrl = sb(B_READ) | sb(B_MDR_IN);
         T3: ctrl = sb(B_MDR_OUT) | sb(B_IR_IN);
         T4: case (cls)
            C_RTYPE, C_IMM:    ctrl = sb(B_GRB) | sb(B_R_OUT) | sb(B_Y_IN);
            C_LD, C_LDI, C_ST: ctrl = sb(B_GRB) | sb(B_BA_OUT) | sb(B_Y_IN);
            C_UNARY:           ctrl = sb(B_GRB) | sb(B_R_OUT) | sb(B_ZLOW_IN);
            C_MULDIV:          ctrl = sb(B_GRA) | sb(B_R_OUT) | sb(B_Y_IN);
            C_BR:              ctrl = sb(B_GRA) | sb(B_R_OUT) | sb(B_CON_IN);
            C_JR:              ctrl = sb(B_GRA) | sb(B_R_OUT) | sb(B_PC_IN);
            C_JAL:             ctrl = sb(B_PC_OUT) | sb(B_GRB) | sb(B_R_IN);
            C_IN:              ctrl = sb(B_INPORT_OUT) | sb(B_GRA) | sb(B_R_IN);
            C_OUT:             ctrl = sb(B_GRA) | sb(B_R_OUT) | sb(B_OUTPORT_IN);
            C_MFHI:            ctrl = sb(B_HI_OUT) | sb(B_GRA) | sb(B_R_IN);
            C_MFLO:            ctrl = sb(B_LO_OUT) | sb(B_GRA) | sb(B_R_IN);
            default:           ;
         endcase
         T5: case (cls)
            C_RTYPE:                  ctrl = sb(B_GRC) | sb(B_R_OUT) | sb(B_ZLOW_IN);
            C_IMM, C_LD, C_LDI, C_ST: ctrl = sb(B_C_OUT) | sb(B_ZLOW_IN);
            C_UNARY:                  ctrl = sb(B_ZLOW_OUT) | sb(B_GRA) | sb(B_R_IN);
            C_MULDIV:                 ctrl = sb(B_GRB) | sb(B_R_OUT) | sb(B_ZHIGH_IN) | sb(B_ZLOW_IN);
            C_BR:                     ctrl = sb(B_PC_OUT) | sb(B_Y_IN);
            C_JAL:                    ctrl = sb(B_GRA) | sb(B_R_OUT) | sb(B_PC_IN);
            default:                  ;
         endcase
         T6: case (cls)
            C_RTYPE, C_IMM, C_LDI: ctrl = sb(B_ZLOW_OUT) | sb(B_GRA) | sb(B_R_IN);
            C_LD, C_ST:            ctrl = sb(B_ZLOW_OUT) | sb(B_MAR_IN);
            C_MULDIV:              ctrl = sb(B_ZLOW_OUT) | sb(B_LO_IN);
            C_BR:                  ctrl = sb(B_C_OUT) | sb(B_ZLOW_IN);
            default:               ;
         endcase
         T7: case (cls)
            C_MULDIV: ctrl = sb(B_ZHIGH_OUT) | sb(B_HI_IN);
            C_LD:     ctrl = sb(B_READ);
            C_ST:     ctrl = sb(B_GRA) | sb(B_R_OUT) | sb(B_MDR_IN);
            C_BR:     ctrl = con_ff ? sb(B_ZLOW_OUT) | sb(B_PC_IN) : '0;
            default:  ;
         endcase
         T8: ctrl = (cls == C_LD) ? sb(B_READ) | sb(B_MDR_IN) : (cls == C_ST) ? sb(B_WRITE) : '0;
         T9: ctrl = (cls == C_LD) ? sb(B_MDR_OUT) | sb(B_GRA) | sb(B_R_IN) : '0;
         default: ;
      endcase
   end

   // ALU code is driven only while Z is being loaded; address/branch math uses add
   always_comb begin
      alu_sel = (cls inside {C_LD, C_LDI, C_ST, C_BR} || opcode == OP_ADDI) ? OP_ADD :
                (opcode == OP_ANDI) ? OP_AND : (opcode == OP_ORI) ? OP_OR : opcode;
      alu_op  = (ctrl[B_ZLOW_IN] || ctrl[B_ZHIGH_IN]) ? alu_sel : 5'b0;
   end

endmodule

// File: rtl/control_unit.sv
// control_unit: Moore sequencer holding the step counter, run/halt mode and stop request
module control_unit #(
   parameter int CTRL_W = 29
) (
   input  logic              clock,
   input  logic              clear,
   input  logic [31:0]       ir,
   input  logic              con_ff,
   input  logic              stop,
   output logic [CTRL_W-1:0] ctrl,
   output logic [4:0]        alu_op,
   output logic              run,
   output logic [3:0]        step
);

   import cpu_pkg::*;

   mode_t                      mode_q, mode_d;
   step_t                      step_q, step_d;
   logic                       stop_q, stop_d;
   logic                       at_last;
   logic [cpu_pkg::CTRL_W-1:0] dec_ctrl;
   logic [4:0]                 dec_alu;
   logic                       unused_ir;

   assign unused_ir = ^ir[26:0];
   assign run       = (mode_q == M_RUN);
   assign step      = step_q;
   assign at_last   = (step_q == last_step(op_class(ir[31:27])));
   assign ctrl      = run ? dec_ctrl : '0;
   assign alu_op    = run ? dec_alu : 5'b0;

   control_decode u_decode (
      .step   (step_q),
      .opcode (ir[31:27]),
      .con_ff (con_ff),
      .ctrl   (dec_ctrl),
      .alu_op (dec_alu)
   );

   // Advance through the steps; at the last step wrap to T0 or halt on a pending stop/halt
   always_comb begin
      mode_d = mode_q;
      step_d = step_q;
      stop_d = stop_q | (run & stop);
      if (mode_q == M_IDLE) mode_d = M_RUN;
      else if (run) begin
         step_d = at_last ? T0 : step_t'(step_q + 4'd1);
         if (at_last && (stop_d || op_class(ir[31:27]) == C_HALT)) mode_d = M_HALT;
      end
   end

   // State register; reset parks in IDLE so all outputs are quiet until clear rises
   always_ff @(posedge clock) begin
      if (!clear) begin
         mode_q <= M_IDLE;
         step_q <= T0;
         stop_q <= 1'b0;
      end else begin
         mode_q <= mode_d;
         step_q <= step_d;
         stop_q <= stop_d;
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for the control sequencer
module tb_control_unit;

   localparam logic [28:0] PCO  = 29'd1 << 0,  ZHO  = 29'd1 << 1,  ZLO  = 29'd1 << 2;
   localparam logic [28:0] MDRO = 29'd1 << 3,  BAO  = 29'd1 << 4,  RIN  = 29'd1 << 5;
   localparam logic [28:0] ROUT = 29'd1 << 6,  HIO  = 29'd1 << 7,  LOO  = 29'd1 << 8;
   localparam logic [28:0] COUT = 29'd1 << 10, MARI = 29'd1 << 11, PCI  = 29'd1 << 12;
   localparam logic [28:0] MDRI = 29'd1 << 13, IRI  = 29'd1 << 14, YIN  = 29'd1 << 15;
   localparam logic [28:0] INC  = 29'd1 << 16, RD   = 29'd1 << 17, WR   = 29'd1 << 18;
   localparam logic [28:0] GRA  = 29'd1 << 19, GRB  = 29'd1 << 20, GRC  = 29'd1 << 21;
   localparam logic [28:0] HII  = 29'd1 << 22, LOI  = 29'd1 << 23, ZHI  = 29'd1 << 24;
   localparam logic [28:0] ZLI  = 29'd1 << 25, CONI = 29'd1 << 26;
   localparam logic [28:0] F0 = PCO | MARI | INC | PCI, F1 = RD, F2 = RD | MDRI, F3 = MDRO | IRI;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        con_ff = 1'b0;
   logic        stop = 1'b0;
   logic [31:0] ir = 32'h0;
   logic [28:0] ctrl;
   logic [4:0]  alu_op;
   logic        run;
   logic [3:0]  step;
   int          checks = 0;
   int          errors = 0;

   control_unit #(.CTRL_W(29)) dut (
      .clock  (clock),
      .clear  (clear),
      .ir     (ir),
      .con_ff (con_ff),
      .stop   (stop),
      .ctrl   (ctrl),
      .alu_op (alu_op),
      .run    (run),
      .step   (step)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      clear = 1'b0;
      tick();
      checks++;
      if (run !== 1'b0 || ctrl !== 29'd0 || alu_op !== 5'd0 || step !== 4'd0) begin
         errors++;
         $display("FAIL reset_hold: run=%b ctrl=%h alu=%b step=%0d, expected all 0", run, ctrl, alu_op, step);
      end
      clear = 1'b1;
      tick();
      checks++;
      if (run !== 1'b1 || ctrl !== F0 || step !== 4'd0) begin
         errors++;
         $display("FAIL reset_release: run=%b ctrl=%h step=%0d, expected run=1 ctrl=%h step=0", run, ctrl, step, F0);
      end
   endtask

   task automatic test_add();
      logic [28:0] ec [7] = '{F0, F1, F2, F3, GRB | ROUT | YIN, GRC | ROUT | ZLI, ZLO | GRA | RIN};
      logic [4:0]  ea [7] = '{0, 0, 0, 0, 0, 5'b00011, 0};
      ir = 32'h19890000;
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (step !== 4'(i) || ctrl !== ec[i] || alu_op !== ea[i] || run !== 1'b1) begin
            errors++;
            $display("FAIL add_T%0d: step=%0d ctrl=%h alu=%b run=%b, expected ctrl=%h alu=%b", i, step, ctrl, alu_op, run, ec[i], ea[i]);
         end
         tick();
      end
      checks++;
      if (step !== 4'd0 || ctrl !== F0) begin
         errors++;
         $display("FAIL add_wrap: step=%0d ctrl=%h, expected step=0 ctrl=%h", step, ctrl, F0);
      end
   endtask

   task automatic test_ld();
      logic [28:0] ec [10] = '{F0, F1, F2, F3, GRB | BAO | YIN, COUT | ZLI, ZLO | MARI, RD, RD | MDRI, MDRO | GRA | RIN};
      logic [4:0]  ea [10] = '{0, 0, 0, 0, 0, 5'b00011, 0, 0, 0, 0};
      ir = 32'h01880005;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (step !== 4'(i) || ctrl !== ec[i] || alu_op !== ea[i]) begin
            errors++;
            $display("FAIL ld_T%0d: step=%0d ctrl=%h alu=%b, expected ctrl=%h alu=%b", i, step, ctrl, alu_op, ec[i], ea[i]);
         end
         tick();
      end
      checks++;
      if (step !== 4'd0 || ctrl !== F0) begin
         errors++;
         $display("FAIL ld_wrap: step=%0d ctrl=%h, expected step=0 ctrl=%h", step, ctrl, F0);
      end
   endtask

   task automatic test_mul();
      logic [28:0] ec [8] = '{F0, F1, F2, F3, GRA | ROUT | YIN, GRB | ROUT | ZHI | ZLI, ZLO | LOI, ZHO | HII};
      logic [4:0]  ea [8] = '{0, 0, 0, 0, 0, 5'b10000, 0, 0};
      ir = 32'h80880000;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (step !== 4'(i) || ctrl !== ec[i] || alu_op !== ea[i]) begin
            errors++;
            $display("FAIL mul_T%0d: step=%0d ctrl=%h alu=%b, expected ctrl=%h alu=%b", i, step, ctrl, alu_op, ec[i], ea[i]);
         end
         tick();
      end
      checks++;
      if (step !== 4'd0) begin
         errors++;
         $display("FAIL mul_wrap: step=%0d, expected 0", step);
      end
   endtask

   task automatic test_br(input logic c);
      logic [28:0] ec [8] = '{F0, F1, F2, F3, GRA | ROUT | CONI, PCO | YIN, COUT | ZLI, c ? ZLO | PCI : 29'd0};
      logic [4:0]  ea [8] = '{0, 0, 0, 0, 0, 0, 5'b00011, 0};
      ir = 32'h98000010;
      con_ff = c;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (step !== 4'(i) || ctrl !== ec[i] || alu_op !== ea[i]) begin
            errors++;
            $display("FAIL br%0d_T%0d: step=%0d ctrl=%h alu=%b, expected ctrl=%h alu=%b", c, i, step, ctrl, alu_op, ec[i], ea[i]);
         end
         tick();
      end
      con_ff = 1'b0;
      checks++;
      if (step !== 4'd0 || ctrl !== F0) begin
         errors++;
         $display("FAIL br%0d_wrap: step=%0d ctrl=%h, expected step=0 ctrl=%h", c, step, ctrl, F0);
      end
   endtask

   task automatic test_short();
      logic [31:0] it [3] = '{32'hA0000000, 32'hA8000000, 32'hF8000000};
      logic [28:0] e4 [3] = '{GRA | ROUT | PCI, PCO | GRB | RIN, 29'd0};
      logic [28:0] e5 [3] = '{F0, GRA | ROUT | PCI, F0};
      int          len [3] = '{5, 6, 5};
      for (int k = 0; k < 3; k++) begin
         ir = it[k];
         for (int i = 0; i < 4; i++) tick();
         checks++;
         if (step !== 4'd4 || ctrl !== e4[k]) begin
            errors++;
            $display("FAIL short%0d_T4: step=%0d ctrl=%h, expected step=4 ctrl=%h", k, step, ctrl, e4[k]);
         end
         tick();
         checks++;
         if (step !== (len[k] == 6 ? 4'd5 : 4'd0) || ctrl !== e5[k]) begin
            errors++;
            $display("FAIL short%0d_next: step=%0d ctrl=%h, expected ctrl=%h", k, step, ctrl, e5[k]);
         end
         if (len[k] == 6) tick();
      end
   endtask

   task automatic test_st();
      logic [28:0] ec [9] = '{F0, F1, F2, F3, GRB | BAO | YIN, COUT | ZLI, ZLO | MARI, GRA | ROUT | MDRI, WR};
      ir = 32'h11880003;
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (step !== 4'(i) || ctrl !== ec[i]) begin
            errors++;
            $display("FAIL st_T%0d: step=%0d ctrl=%h, expected ctrl=%h", i, step, ctrl, ec[i]);
         end
         tick();
      end
      checks++;
      if (step !== 4'd0) begin
         errors++;
         $display("FAIL st_wrap: step=%0d, expected 0", step);
      end
   endtask

   task automatic test_clear_mid_st();
      ir = 32'h11880003;
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (ctrl[18] !== 1'b0 || step !== 4'(i)) begin
            errors++;
            $display("FAIL clr_st_T%0d: step=%0d write=%b, expected step=%0d write=0", i, step, ctrl[18], i);
         end
         if (i < 6) tick();
      end
      clear = 1'b0;
      tick();
      checks++;
      if (ctrl !== 29'd0 || alu_op !== 5'd0 || run !== 1'b0) begin
         errors++;
         $display("FAIL clr_st_quiet: ctrl=%h alu=%b run=%b, expected all 0", ctrl, alu_op, run);
      end
      clear = 1'b1;
      tick();
      checks++;
      if (step !== 4'd0 || ctrl !== F0 || run !== 1'b1) begin
         errors++;
         $display("FAIL clr_st_restart: step=%0d ctrl=%h run=%b, expected step=0 ctrl=%h run=1", step, ctrl, run, F0);
      end
   endtask

   task automatic test_halt();
      int bad = 0;
      ir = 32'hD8000000;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (step !== 4'd4 || ctrl !== 29'd0 || run !== 1'b1) begin
         errors++;
         $display("FAIL halt_T4: step=%0d ctrl=%h run=%b, expected step=4 ctrl=0 run=1", step, ctrl, run);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (run !== 1'b0 || ctrl !== 29'd0 || alu_op !== 5'd0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL halt_hold: %0d of 20 cycles active, expected 0", bad);
      end
      clear = 1'b0;
      tick();
      clear = 1'b1;
      tick();
      checks++;
      if (step !== 4'd0 || ctrl !== F0 || run !== 1'b1) begin
         errors++;
         $display("FAIL halt_restart: step=%0d ctrl=%h run=%b, expected step=0 ctrl=%h run=1", step, ctrl, run, F0);
      end
   endtask

   task automatic test_stop();
      int bad = 0;
      ir = 32'h19890000;
      for (int i = 0; i < 5; i++) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if (step !== 4'd6 || ctrl !== (ZLO | GRA | RIN) || run !== 1'b1) begin
         errors++;
         $display("FAIL stop_T6: step=%0d ctrl=%h run=%b, expected step=6 ctrl=%h run=1", step, ctrl, run, ZLO | GRA | RIN);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         if (run !== 1'b0 || ctrl !== 29'd0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL stop_halted: %0d of 5 cycles active, expected 0", bad);
      end
      clear = 1'b0;
      tick();
      clear = 1'b1;
      tick();
   endtask

   initial begin
      tick();
      tick();
      test_reset();
      test_add();
      test_ld();
      test_mul();
      test_br(1'b1);
      test_br(1'b0);
      test_short();
      test_st();
      test_clear_mid_st();
      test_halt();
      test_stop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
